// File: rtl/cmd_exec_ctrl.sv
// Command executor: runs decoded W/R commands against a register file and returns one response byte over a tx handshake.
// Optional macro CMD_ECHO_EN: echo the opcode byte before every response.
module cmd_exec_ctrl #(
    parameter int         ADDR_W   = 4,
    parameter logic [7:0] ACK_BYTE = 8'h4B,
    parameter logic [7:0] ERR_BYTE = 8'h45
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    input  logic [7:0]        cmd,
    input  logic [7:0]        addr,
    input  logic [7:0]        data,
    output logic              busy,
    output logic              cmd_dropped,
    output logic              rf_we,
    output logic              rf_re,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [7:0]        rf_wdata,
    input  logic [7:0]        rf_rdata,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic              tx_ready
);

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        READ_WAIT,
`ifdef CMD_ECHO_EN
        ECHO,
`endif
        RESP
    } state_t;

`ifdef CMD_ECHO_EN
    localparam state_t RESP_ENTRY = ECHO;
`else
    localparam state_t RESP_ENTRY = RESP;
`endif

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        data_q;
    logic [7:0]        resp_q;
    logic [7:0]        resp_next;
    logic              resp_load;
    logic              addr_ok;
`ifdef CMD_ECHO_EN
    logic [7:0]        cmd_q;
`endif

    // Addresses with any bit set at or above ADDR_W are outside the register file.
    assign addr_ok = ((addr >> ADDR_W) == 8'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        resp_load  = 1'b0;
        resp_next  = resp_q;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd == OP_WRITE && addr_ok) begin
                        state_next = WRITE;
                    end else if (cmd == OP_READ && addr_ok) begin
                        state_next = READ;
                    end else begin
                        state_next = RESP_ENTRY;
                        resp_load  = 1'b1;
                        resp_next  = ERR_BYTE;
                    end
                end
            end
            WRITE: begin
                state_next = RESP_ENTRY;
                resp_load  = 1'b1;
                resp_next  = ACK_BYTE;
            end
            READ: begin
                state_next = READ_WAIT;
            end
            READ_WAIT: begin
                state_next = RESP_ENTRY;
                resp_load  = 1'b1;
                resp_next  = rf_rdata;
            end
`ifdef CMD_ECHO_EN
            ECHO: begin
                if (tx_ready) begin
                    state_next = RESP;
                end
            end
`endif
            RESP: begin
                if (tx_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Command fields are captured only on acceptance, so dropped commands never disturb them.
    always_ff @(posedge clk) begin
        if (state == IDLE && cmd_valid) begin
            addr_q <= addr[ADDR_W-1:0];
            data_q <= data;
`ifdef CMD_ECHO_EN
            cmd_q  <= cmd;
`endif
        end
        if (resp_load) begin
            resp_q <= resp_next;
        end
    end

    // Data outputs are gated by state so they read zero whenever they carry nothing.
    always_comb begin
        busy        = (state != IDLE);
        cmd_dropped = cmd_valid && (state != IDLE);
        rf_we       = (state == WRITE);
        rf_re       = (state == READ);
        rf_addr     = '0;
        rf_wdata    = 8'd0;
        tx_valid    = 1'b0;
        tx_data     = 8'd0;
        if (state == WRITE || state == READ) begin
            rf_addr = addr_q;
        end
        if (state == WRITE) begin
            rf_wdata = data_q;
        end
        if (state == RESP) begin
            tx_valid = 1'b1;
            tx_data  = resp_q;
        end
`ifdef CMD_ECHO_EN
        if (state == ECHO) begin
            tx_valid = 1'b1;
            tx_data  = cmd_q;
        end
`endif
    end

endmodule

// File: tb/tb_cmd_exec_ctrl.sv
// Bench for cmd_exec_ctrl: transaction-level model of expected rf accesses and tx bytes, checked every cycle.
module tb_cmd_exec_ctrl;

    localparam int ADDR_W = 4;
`ifdef CMD_ECHO_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_valid = 1'b0;
    logic [7:0]        cmd = 8'd0;
    logic [7:0]        addr = 8'd0;
    logic [7:0]        data = 8'd0;
    logic              busy;
    logic              cmd_dropped;
    logic              rf_we;
    logic              rf_re;
    logic [ADDR_W-1:0] rf_addr;
    logic [7:0]        rf_wdata;
    logic [7:0]        rf_rdata = 8'd0;
    logic              tx_valid;
    logic [7:0]        tx_data;
    logic              tx_ready = 1'b1;

    always #5 clk = ~clk;

    cmd_exec_ctrl #(.ADDR_W(ADDR_W), .ACK_BYTE(8'h4B), .ERR_BYTE(8'h45)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd), .addr(addr), .data(data),
        .busy(busy), .cmd_dropped(cmd_dropped), .rf_we(rf_we), .rf_re(rf_re),
        .rf_addr(rf_addr), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready)
    );

    // Register file seen by the DUT: read data appears the cycle after rf_re.
    logic [7:0] rf_mem [0:15];
    always @(posedge clk) begin
        if (rf_we) rf_mem[rf_addr] <= rf_wdata;
        if (rf_re) rf_rdata <= rf_mem[rf_addr];
    end

    typedef struct {
        logic       we;
        logic [3:0] a;
        logic [7:0] d;
    } rf_op_t;

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         acc_cyc = 0;
    int         exp_lat = 0;
    bit         first_pending = 0;
    logic       model_busy = 1'b0;
    logic       mb;
    logic [7:0] resp;
    rf_op_t     op;
    rf_op_t     exp_rf[$];
    logic [7:0] exp_tx[$];
    logic [7:0] tx_log[$];
    logic [7:0] ref_mem [0:15];
    int         drop_cnt = 0;
    int         we_cnt = 0;
    int         re_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s actual=event required=none", name);
    endtask

    // Compare process: model advances once per cycle on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            chk("reset_outputs", {7'd0, busy, cmd_dropped, rf_we, rf_re, tx_valid, tx_data, rf_addr, rf_wdata}, 32'd0);
            exp_rf.delete();
            exp_tx.delete();
            model_busy    = 1'b0;
            first_pending = 0;
        end else begin
            mb = model_busy;
            chk("busy", {31'd0, busy}, {31'd0, mb});
            chk("cmd_dropped", {31'd0, cmd_dropped}, {31'd0, cmd_valid && mb});
            if (cmd_dropped) drop_cnt++;
            if (rf_we && rf_re) fail_now("strobe_exclusive");
            if (rf_we || rf_re) begin
                if (rf_we) we_cnt++;
                if (rf_re) re_cnt++;
                if (exp_rf.size() == 0) begin
                    fail_now("rf_unexpected");
                end else begin
                    op = exp_rf.pop_front();
                    chk("rf_kind", {31'd0, rf_we}, {31'd0, op.we});
                    chk("rf_addr", {28'd0, rf_addr}, {28'd0, op.a});
                    chk("rf_latency", cyc - acc_cyc, 1);
                    if (op.we) begin
                        chk("rf_wdata", {24'd0, rf_wdata}, {24'd0, op.d});
                        ref_mem[op.a] = op.d;
                    end
                end
            end
            if (tx_valid) begin
                if (exp_tx.size() == 0) begin
                    fail_now("tx_unexpected");
                end else begin
                    chk("tx_data", {24'd0, tx_data}, {24'd0, exp_tx[0]});
                    if (first_pending) begin
                        chk("tx_latency", cyc - acc_cyc, exp_lat);
                        chk("rf_missing", exp_rf.size(), 0);
                        first_pending = 0;
                    end
                    if (tx_ready) begin
                        tx_log.push_back(tx_data);
                        void'(exp_tx.pop_front());
                        if (exp_tx.size() == 0) model_busy = 1'b0;
                    end
                end
            end
            if (cmd_valid && !mb) begin
                if (cmd == 8'h57 && addr < 8'd16) begin
                    exp_rf.push_back('{1'b1, addr[3:0], data});
                    resp    = 8'h4B;
                    exp_lat = 2;
                end else if (cmd == 8'h52 && addr < 8'd16) begin
                    exp_rf.push_back('{1'b0, addr[3:0], 8'd0});
                    resp    = ref_mem[addr[3:0]];
                    exp_lat = 3;
                end else begin
                    resp    = 8'h45;
                    exp_lat = 1;
                end
`ifdef CMD_ECHO_EN
                exp_tx.push_back(cmd);
`endif
                exp_tx.push_back(resp);
                model_busy    = 1'b1;
                acc_cyc       = cyc;
                first_pending = 1;
            end
        end
    end

    task automatic send(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd = c; addr = a; data = d;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) fail_now("wait_idle_timeout");
    endtask

    int log0;
    int drop0;

    initial begin
        for (int i = 0; i < 16; i++) begin
            rf_mem[i]  = 8'd0;
            ref_mem[i] = 8'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("reset_literal", {7'd0, busy, cmd_dropped, rf_we, rf_re, tx_valid, tx_data, rf_addr, rf_wdata}, 32'd0);
        rst = 1'b0;

        // Write then read back the same register.
        log0 = tx_log.size();
        send(8'h57, 8'h03, 8'hAA);
        wait_idle();
        chk("w03_bytes", tx_log.size() - log0, NB);
        chk("w03_ack", {24'd0, tx_log[$]}, 32'h4B);
        chk("w03_we_cnt", we_cnt, 1);
        send(8'h52, 8'h03, 8'h00);
        wait_idle();
        chk("r03_data", {24'd0, tx_log[$]}, 32'hAA);
        chk("r03_counts", {we_cnt[15:0], re_cnt[15:0]}, {16'd1, 16'd1});

        // Bad opcode and out-of-range address.
        send(8'h58, 8'h00, 8'h00);
        wait_idle();
        chk("badop_err", {24'd0, tx_log[$]}, 32'h45);
        send(8'h57, 8'h10, 8'h77);
        wait_idle();
        chk("badaddr_err", {24'd0, tx_log[$]}, 32'h45);
        chk("err_no_rf", {we_cnt[15:0], re_cnt[15:0]}, {16'd1, 16'd1});

        // Highest legal address.
        send(8'h57, 8'h0F, 8'h3C);
        wait_idle();
        send(8'h52, 8'h0F, 8'h00);
        wait_idle();
        chk("r0f_data", {24'd0, tx_log[$]}, 32'h3C);

        // Stall the transmitter, drop a command meanwhile, then release.
        tx_ready = 1'b0;
        log0  = tx_log.size();
        drop0 = drop_cnt;
        send(8'h57, 8'h05, 8'h66);
        repeat (3) @(posedge clk);
        send(8'h52, 8'h05, 8'h00);
        repeat (5) @(posedge clk);
        #1;
        chk("stall_tx_valid", {31'd0, tx_valid}, 32'd1);
        chk("stall_no_bytes", tx_log.size() - log0, 0);
        chk("stall_drop_once", drop_cnt - drop0, 1);
        tx_ready = 1'b1;
        wait_idle();
        chk("stall_release_bytes", tx_log.size() - log0, NB);
        chk("stall_ack", {24'd0, tx_log[$]}, 32'h4B);
`ifdef CMD_ECHO_EN
        chk("stall_echo_cmd", {24'd0, tx_log[tx_log.size() - 2]}, 32'h57);
`endif
        send(8'h52, 8'h05, 8'h00);
        wait_idle();
        chk("r05_data", {24'd0, tx_log[$]}, 32'h66);

        // Reset in READ_WAIT abandons the read.
        log0 = tx_log.size();
        send(8'h52, 8'h03, 8'h00);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("async_reset", {7'd0, busy, cmd_dropped, rf_we, rf_re, tx_valid, tx_data, rf_addr, rf_wdata}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("reset_abandon", tx_log.size() - log0, 0);
        send(8'h57, 8'h01, 8'h55);
        wait_idle();
        chk("w01_ack", {24'd0, tx_log[$]}, 32'h4B);
        send(8'h52, 8'h01, 8'h00);
        wait_idle();
        chk("r01_data", {24'd0, tx_log[$]}, 32'h55);

`ifdef CMD_ECHO_EN
        log0 = tx_log.size();
        send(8'h57, 8'h02, 8'h11);
        wait_idle();
        chk("echo_first", {24'd0, tx_log[log0]}, 32'h57);
        chk("echo_second", {24'd0, tx_log[log0 + 1]}, 32'h4B);
`endif

        repeat (2) @(posedge clk);
        #1;
        chk("model_drained", exp_tx.size() + exp_rf.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
